// File: rtl/j1_io_pkg.sv
// Shared definitions for the j1 I/O responder: address map, status bit layout
// and the UART engine state encoding used by both TX and RX.
package j1_io_pkg;

  localparam logic [15:0] IO_LEDS      = 16'h0000;
  localparam logic [15:0] IO_UART_DATA = 16'h0001;
  localparam logic [15:0] IO_UART_STAT = 16'h0002;
  localparam logic [15:0] IO_TICKS     = 16'h0003;

  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_RX_VALID   = 1;
  localparam int STAT_RX_OVERRUN = 2;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/j1_uart.sv
// 8N1 UART: transmit engine, receive engine with a 2-flop input synchroniser.
// rx_done pulses for one cycle with rx_data valid when a well-framed byte lands.
module j1_uart
  import j1_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       rx_done,
  output logic [7:0] rx_data,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_e   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_shift_q;
  logic          uart_tx_q;

  uart_state_e   rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_done_q;
  logic          rx_s1_q;
  logic          rx_s2_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        UART_IDLE: begin
          if (tx_start) begin
            tx_state_q <= UART_START;
            tx_shift_q <= tx_data;
            tx_cnt_q   <= '0;
            uart_tx_q  <= 1'b0;
          end
        end
        UART_START: begin
          if (tx_cnt_q == LAST) begin
            tx_state_q <= UART_DATA;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            uart_tx_q  <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        UART_DATA: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= UART_STOP;
              uart_tx_q  <= 1'b1;
            end else begin
              // Shift so the next bit to send always sits at index 1 -> 0.
              tx_idx_q   <= tx_idx_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              uart_tx_q  <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        UART_STOP: begin
          if (tx_cnt_q == LAST) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= UART_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= UART_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_done_q <= 1'b0;
      case (rx_state_q)
        UART_IDLE: begin
          if (!rx_s2_q) begin
            rx_state_q <= UART_START;
            rx_cnt_q   <= '0;
          end
        end
        UART_START: begin
          // Mid-start-bit recheck rejects short glitches on the line.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s2_q ? UART_IDLE : UART_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        UART_DATA: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) begin
              rx_state_q <= UART_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        UART_STOP: begin
          if (rx_cnt_q == LAST) begin
            rx_state_q <= UART_IDLE;
            rx_cnt_q   <= '0;
            if (rx_s2_q) begin
              rx_data_q <= rx_shift_q;
              rx_done_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= UART_IDLE;
      endcase
    end
  end

  assign tx_busy = (tx_state_q != UART_IDLE);
  assign uart_tx = uart_tx_q;
  assign rx_done = rx_done_q;
  assign rx_data = rx_data_q;

endmodule

// File: rtl/j1_io_responder.sv
// I/O responder for the j1 core: captures the core's bus one cycle early,
// commits writes the following cycle and serves reads combinationally.
module j1_io_responder
  import j1_io_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] io_din,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic [7:0]       leds
);

  logic [15:0]      addr_q, addr_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       leds_q, leds_d;
  logic [15:0]      ticks_q, ticks_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_overrun_q, rx_overrun_d;

  logic       tx_start;
  logic       tx_busy;
  logic       rx_done;
  logic [7:0] rx_data;

  j1_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .resetq   (resetq),
    .tx_start (tx_start),
    .tx_data  (data_q[7:0]),
    .tx_busy  (tx_busy),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx)
  );

  always_comb begin
    addr_d       = mem_addr;
    wr_d         = io_wr;
    data_d       = dout;
    leds_d       = leds_q;
    ticks_d      = ticks_q + 16'd1;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    tx_start     = 1'b0;
    if (wr_q) begin
      case (addr_q)
        IO_LEDS:      leds_d = data_q[7:0];
        IO_UART_DATA: tx_start = !tx_busy;
        IO_UART_STAT: begin
          rx_valid_d   = 1'b0;
          rx_overrun_d = 1'b0;
        end
        IO_TICKS:     ticks_d = data_q[15:0];
        default:      ;
      endcase
    end
    // A landing byte overrides a same-cycle status clear.
    if (rx_done) begin
      rx_byte_d    = rx_data;
      rx_valid_d   = 1'b1;
      rx_overrun_d = rx_valid_q;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      addr_q       <= '0;
      wr_q         <= 1'b0;
      data_q       <= '0;
      leds_q       <= '0;
      ticks_q      <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      leds_q       <= leds_d;
      ticks_q      <= ticks_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  always_comb begin
    io_din = '0;
    case (addr_q)
      IO_LEDS:      io_din = WIDTH'(leds_q);
      IO_UART_DATA: io_din = WIDTH'(rx_byte_q);
      IO_UART_STAT: begin
        io_din[STAT_TX_BUSY]    = tx_busy;
        io_din[STAT_RX_VALID]   = rx_valid_q;
        io_din[STAT_RX_OVERRUN] = rx_overrun_q;
      end
      IO_TICKS:     io_din = WIDTH'(ticks_q);
      default:      io_din = '0;
    endcase
  end

  assign leds = leds_q;

endmodule
